// File: rtl/bcd_cascade_counter.sv
// Multi-digit BCD up/down counter with clock-enable prescaler.
// Steps once per PRESCALE enabled cycles; flags wrap and zero.
module bcd_cascade_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000,
  parameter int PS_W     = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic                  zero
);

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);

  logic [PS_W-1:0]     ps;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] loaded;
  logic                carry;
  logic [3:0]          d;

  // Carry/borrow ripples through every digit in one cycle;
  // a carry out of the top digit is the wrap condition.
  always_comb begin
    stepped = count;
    carry   = 1'b1;
    d       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    loaded = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        loaded[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ps    <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
        ps    <= '0;
      end else if (load) begin
        count <= loaded;
        ps    <= '0;
      end else if (en) begin
        if (ps == PS_MAX) begin
          ps    <= '0;
          count <= stepped;
          tick  <= 1'b1;
          wrap  <= carry;
        end else begin
          ps <= ps + PS_ONE;
        end
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: three instances with different
// digit counts and prescales; ticks of instance a go to a scoreboard.
module tb_bcd_cascade_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: DIGITS=2, PRESCALE=1
  logic       a_clr = 0, a_load = 0, a_en = 0, a_up = 1;
  logic [7:0] a_lv = '0, a_count;
  logic       a_tick, a_wrap, a_zero;
  // b: DIGITS=2, PRESCALE=4
  logic       b_clr = 0, b_load = 0, b_en = 0, b_up = 1;
  logic [7:0] b_lv = '0, b_count;
  logic       b_tick, b_wrap, b_zero;
  // c: DIGITS=3, PRESCALE=1
  logic        c_clr = 0, c_load = 0, c_en = 0, c_up = 1;
  logic [11:0] c_lv = '0, c_count;
  logic        c_tick, c_wrap, c_zero;

  bcd_cascade_counter #(.DIGITS(2), .PRESCALE(1), .PS_W(1)) u_a (
    .clk(clk), .reset(reset), .clr(a_clr), .load(a_load),
    .load_val(a_lv), .en(a_en), .up(a_up), .count(a_count),
    .tick(a_tick), .wrap(a_wrap), .zero(a_zero)
  );

  bcd_cascade_counter #(.DIGITS(2), .PRESCALE(4), .PS_W(2)) u_b (
    .clk(clk), .reset(reset), .clr(b_clr), .load(b_load),
    .load_val(b_lv), .en(b_en), .up(b_up), .count(b_count),
    .tick(b_tick), .wrap(b_wrap), .zero(b_zero)
  );

  bcd_cascade_counter #(.DIGITS(3), .PRESCALE(1), .PS_W(1)) u_c (
    .clk(clk), .reset(reset), .clr(c_clr), .load(c_load),
    .load_val(c_lv), .en(c_en), .up(c_up), .count(c_count),
    .tick(c_tick), .wrap(c_wrap), .zero(c_zero)
  );

  logic [8:0] exp_q[$];

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every tick of a must match the next entry
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset && (a_tick || a_wrap)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got %h/%b want none",
                 a_count, a_wrap);
      end else begin
        e = exp_q.pop_front();
        if (!a_tick || {a_count, a_wrap} !== e) begin
          errors++;
          $display("FAIL sb_step got %h/%b/t%b want %h/%b",
                   a_count, a_wrap, a_tick, e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    #12 reset = 1'b0;
    edges(1);
    check("rst_count", 32'(a_count), 32'h00);
    check("rst_zero", 32'(a_zero), 32'd1);
    check("rst_tick", 32'({a_tick, a_wrap}), 32'd0);

    // 1: 100 up steps, wrap only on 99->00
    a_en = 1; a_up = 1;
    for (int k = 1; k <= 100; k++)
      exp_q.push_back({bcd2(k % 100), k == 100});
    edges(100);
    a_en = 0;
    edges(1);

    // 2: load 00 then count down
    a_load = 1; a_lv = 8'h00; a_en = 1; a_up = 0;
    edges(1);
    check("load00", 32'(a_count), 32'h00);
    a_load = 0;
    exp_q.push_back({8'h99, 1'b1});
    exp_q.push_back({8'h98, 1'b0});
    edges(2);
    a_en = 0;
    edges(1);
    check("dn_idle", 32'({a_tick, a_wrap}), 32'd0);
    check("dn_hold", 32'(a_count), 32'h98);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    // 4: saturating load, clr beats load
    a_load = 1; a_lv = 8'hA7;
    edges(1);
    check("sat_a7", 32'(a_count), 32'h97);
    a_lv = 8'h3C;
    edges(1);
    check("sat_3c", 32'(a_count), 32'h39);
    a_clr = 1; a_lv = 8'h55;
    edges(1);
    check("clr_cnt", 32'(a_count), 32'h00);
    check("clr_tick", 32'(a_tick), 32'd0);
    check("clr_zero", 32'(a_zero), 32'd1);
    a_clr = 0; a_load = 0;

    // 3: prescale 4, tick every 4th cycle
    b_en = 1; b_up = 1;
    for (int k = 1; k <= 2; k++) begin
      edges(3);
      check("ps_quiet", 32'(b_tick), 32'd0);
      edges(1);
      check("ps_tick", 32'(b_tick), 32'd1);
      check("ps_cnt", 32'(b_count), 32'(k));
    end
    edges(2);
    b_en = 0;
    edges(3);
    check("frz_cnt", 32'(b_count), 32'h02);
    check("frz_tick", 32'(b_tick), 32'd0);
    b_en = 1;
    edges(1);
    check("frz_ps1", 32'(b_tick), 32'd0);
    edges(1);
    check("frz_ps2", 32'(b_tick), 32'd1);
    check("frz_cnt3", 32'(b_count), 32'h03);
    b_en = 0;

    // 5: ripple across digits on 3-digit instance
    c_load = 1; c_lv = 12'h199;
    edges(1);
    c_load = 0; c_en = 1; c_up = 1;
    edges(1);
    c_en = 0;
    check("rip_cnt", 32'(c_count), 32'h200);
    check("rip_wrap", 32'({c_tick, c_wrap}), 32'b10);
    c_load = 1; c_lv = 12'h999;
    edges(1);
    c_load = 0; c_en = 1;
    edges(1);
    c_en = 0;
    check("c_wrap_cnt", 32'(c_count), 32'h000);
    check("c_wrap", 32'({c_tick, c_wrap}), 32'b11);
    c_up = 0; c_en = 1;
    edges(1);
    c_en = 0;
    check("c_borrow", 32'(c_count), 32'h999);

    // 6: async reset mid-count on b
    b_load = 1; b_lv = 8'h57;
    edges(1);
    b_load = 0; b_en = 1;
    edges(2);
    check("pre_rst", 32'(b_count), 32'h57);
    #2 reset = 1'b1;
    #1;
    check("arst_cnt", 32'(b_count), 32'h00);
    check("arst_flags", 32'({b_tick, b_zero}), 32'b01);
    @(negedge clk);
    reset = 1'b0;
    edges(3);
    check("post_q", 32'(b_tick), 32'd0);
    edges(1);
    check("post_cnt", 32'({b_tick, b_count}), 32'h101);
    b_en = 0;
    edges(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
